// File: rtl/engine_scheduler.sv
// Round-robin scheduler that serialises three engines onto one shared port.
// Grants one requester at a time, pulses start/ack, holds the port select
// for the job, and releases on the engine's done or on a watchdog timeout.
module engine_scheduler #(
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] req,
  input  logic [2:0] done,
  output logic [2:0] ack,
  output logic [2:0] start,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] err_id
);

  localparam int unsigned CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RUN, RELEASE} state_t;

  state_t        state, state_n;
  logic [1:0]    last_ptr, last_ptr_n;
  logic [1:0]    cur, cur_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    ack_n, start_n;
  logic [1:0]    sel_n, err_id_n;
  logic          busy_n, timeout_err_n;
  logic [1:0]    win, p;
  logic          found;

  // State and registered outputs; all outputs come from flops, never from inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_ptr    <= 2'd2;
      cur         <= '0;
      cnt         <= '0;
      ack         <= '0;
      start       <= '0;
      sel         <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_id      <= '0;
    end else begin
      state       <= state_n;
      last_ptr    <= last_ptr_n;
      cur         <= cur_n;
      cnt         <= cnt_n;
      ack         <= ack_n;
      start       <= start_n;
      sel         <= sel_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
      err_id      <= err_id_n;
    end
  end

  // Round-robin search starting after last_ptr, wrapping 2 -> 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    p     = last_ptr;
    for (int unsigned i = 0; i < 3; i++) begin
      p = (p == 2'd2) ? 2'd0 : p + 2'd1;
      if (!found && req[p]) begin
        found = 1'b1;
        win   = p;
      end
    end
  end

  // Next-state and next-output values; outputs are computed one cycle ahead
  // so the registered copies line up with the state they belong to.
  always_comb begin
    state_n       = state;
    last_ptr_n    = last_ptr;
    cur_n         = cur;
    cnt_n         = cnt;
    ack_n         = '0;
    start_n       = '0;
    sel_n         = sel;
    busy_n        = busy;
    timeout_err_n = 1'b0;
    err_id_n      = err_id;
    case (state)
      IDLE: begin
        if (enable && found) begin
          state_n = GRANT;
          cur_n   = win;
          start_n = 3'b001 << win;
          ack_n   = 3'b001 << win;
          sel_n   = win + 2'd1;
          busy_n  = 1'b1;
        end
      end
      GRANT: begin
        cnt_n      = '0;
        last_ptr_n = cur;
        state_n    = RUN;
      end
      RUN: begin
        if (done[cur]) begin
          state_n = RELEASE;
          sel_n   = '0;
          busy_n  = 1'b0;
        end else if (cnt == TERM) begin
          state_n       = RELEASE;
          sel_n         = '0;
          busy_n        = 1'b0;
          timeout_err_n = 1'b1;
          err_id_n      = cur + 2'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_engine_scheduler.sv
// Randomised self-checking bench for engine_scheduler against a job-level
// reference model (owner, job age, release cooldown, round-robin pointer).
module tb_engine_scheduler;

  localparam int unsigned MAXC   = 8;
  localparam int unsigned NCYCLE = 3000;

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic [2:0] req, done;
  logic [2:0] ack, start;
  logic [1:0] sel, err_id;
  logic       busy, timeout_err;

  always #5 clk = ~clk;

  engine_scheduler #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .done(done),
    .ack(ack), .start(start), .sel(sel), .busy(busy),
    .timeout_err(timeout_err), .err_id(err_id)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: m_owner 0 = port free, else engine 1..3 owns it.
  // m_age 0 is the start cycle; m_age a>=1 is the a-th cycle of running.
  // The job times out after MAXC running cycles; m_cool counts the forced gap.
  int   m_owner = 0, m_age = 0, m_cool = 0, m_last = 3, m_err_id = 0;
  logic m_startp = 1'b0, m_terr = 1'b0;
  int   n_timeouts = 0, n_grants = 0;

  always @(posedge clk) begin
    bit picked;
    int cand;
    if (!rst_n) begin
      m_owner = 0; m_age = 0; m_cool = 0; m_last = 3; m_err_id = 0;
      m_startp = 1'b0; m_terr = 1'b0;
    end else begin
      m_startp = 1'b0;
      m_terr   = 1'b0;
      if (m_owner != 0) begin
        if (m_age == 0) m_age = 1;
        else if (done[m_owner-1]) begin
          m_owner = 0; m_cool = 1;
        end else if (m_age == MAXC) begin
          m_terr = 1'b1; m_err_id = m_owner; m_owner = 0; m_cool = 1;
          n_timeouts++;
        end else m_age++;
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (enable && req != 3'b000) begin
        picked = 0;
        for (int k = 1; k <= 3; k++) begin
          cand = ((m_last - 1 + k) % 3) + 1;
          if (!picked && req[cand-1]) begin
            picked = 1; m_owner = cand; m_age = 0; m_last = cand; m_startp = 1'b1;
          end
        end
        n_grants++;
      end
    end
  end

  task automatic compare_all();
    logic [2:0] exp_oh;
    exp_oh = (m_startp && m_owner != 0) ? (3'b001 << (m_owner - 1)) : 3'b000;
    check_eq("sel",         32'(sel),         32'(m_owner));
    check_eq("busy",        32'(busy),        32'(m_owner != 0));
    check_eq("start",       32'(start),       32'(exp_oh));
    check_eq("ack",         32'(ack),         32'(exp_oh));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));
    check_eq("err_id",      32'(err_id),      32'(m_err_id));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; req = '0; done = '0;
    repeat (3) @(negedge clk);
    compare_all();
    rst_n = 1'b1; enable = 1'b1;
    for (int unsigned c = 0; c < NCYCLE; c++) begin
      @(negedge clk);
      compare_all();
      // Requesters: raise randomly, hold until acked, occasionally withdraw.
      for (int b = 0; b < 3; b++) begin
        if (req[b]) begin
          if (m_startp && m_owner == b + 1 && ($urandom % 10) < 8) req[b] = 1'b0;
          else if (($urandom % 100) < 3) req[b] = 1'b0;
        end else if (($urandom % 100) < 25) req[b] = 1'b1;
      end
      // Engines: owner may finish (often right at the terminal count); others stray.
      done = '0;
      for (int e = 0; e < 3; e++) begin
        if (m_owner == e + 1 && m_age >= 1)
          done[e] = ($urandom % 100) < ((m_age == MAXC) ? 50 : 15);
        else
          done[e] = ($urandom % 100) < 8;
      end
      if (($urandom % 100) < 6) enable = (($urandom % 4) != 0);
      rst_n = (($urandom % 200) != 0);
    end
    @(negedge clk);
    compare_all();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
